// File: rtl/fir_tap_sequencer_if.sv
// Control/status bundle between the sample-input side and the FIR tap sequencer.
// Latency: none (wires only).
// Backpressure: StopIn travels towards the sequencer and stalls it in place.
interface fir_tap_sequencer_if #(
  parameter int NUM_TAPS = 16
);
  localparam int TAP_W = ($clog2(NUM_TAPS) > 1) ? $clog2(NUM_TAPS) : 1;

  logic             Start;
  logic             StopIn;
  logic [TAP_W-1:0] TapAddr;
  logic             MacEn;
  logic             ClearAcc;
  logic             Busy;
  logic             Read;
  logic             Overrun;

  // Upstream controller: launches samples and stalls; observes datapath controls.
  modport master (
    output Start, StopIn,
    input  TapAddr, MacEn, ClearAcc, Busy, Read, Overrun
  );

  // Sequencer side.
  modport slave (
    input  Start, StopIn,
    output TapAddr, MacEn, ClearAcc, Busy, Read, Overrun
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: per Start, steps TapAddr over all taps with MAC enables, drains the MAC pipe, then raises Read.
// Latency: Start sampled at edge k -> RUN k+1..k+NUM_TAPS, DRAIN_CYCLES drain cycles, Read at k+1+NUM_TAPS+DRAIN_CYCLES.
// Backpressure: StopIn freezes RUN/DRAIN/DONE (one extra cycle per stall cycle); Starts not accepted are dropped.
// Optional: define FIR_SEQ_OVERRUN_EN to build the sticky dropped-Start detector; otherwise Overrun is tied 0.
module fir_tap_sequencer #(
  parameter int NUM_TAPS     = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input logic                Clk,
  input logic                Reset,
  fir_tap_sequencer_if.slave seq
);

  localparam int TAP_W = ($clog2(NUM_TAPS) > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int DRN_W = ($clog2(DRAIN_CYCLES + 1) > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
  // With no drain stage the counter is never consulted; keep the constant in range anyway.
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [TAP_W-1:0] tap, tap_nxt;
  logic [DRN_W-1:0] dcnt, dcnt_nxt;

  // State, tap index and drain counter registers; Reset wins over everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      tap   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      tap   <= tap_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next-state logic: StopIn holds everything in RUN/DRAIN/DONE; it is ignored in IDLE.
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        if (seq.Start) begin
          state_nxt = RUN;
          tap_nxt   = '0;
        end
      end
      RUN: begin
        if (!seq.StopIn) begin
          if (tap == TAP_LAST) begin
            dcnt_nxt  = '0;
            state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          end else begin
            tap_nxt = tap + TAP_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!seq.StopIn) begin
          if (dcnt == DRN_LAST) begin
            state_nxt = DONE;
          end else begin
            dcnt_nxt = dcnt + DRN_W'(1);
          end
        end
      end
      DONE: begin
        // Result held while the consumer stalls; otherwise chain straight into the next sample.
        if (!seq.StopIn) begin
          if (seq.Start) begin
            state_nxt = RUN;
            tap_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // TapAddr keeps its last value through DRAIN/DONE/IDLE until the next RUN entry.
  assign seq.TapAddr  = tap;
  // A stalled RUN cycle must not issue a MAC, so the RUN decode is qualified by StopIn.
  // ClearAcc rides with the tap-0 MAC, which also re-issues it if tap 0 was stalled.
  assign seq.MacEn    = (state == RUN) && !seq.StopIn;
  assign seq.ClearAcc = (state == RUN) && (tap == '0) && !seq.StopIn;
  assign seq.Busy     = (state == RUN) || (state == DRAIN);
  assign seq.Read     = (state == DONE);

`ifdef FIR_SEQ_OVERRUN_EN
  logic start_drop;
  logic overrun;

  // A Start is dropped anywhere except IDLE or an unstalled DONE.
  assign start_drop = seq.Start &&
                      ((state == RUN) || (state == DRAIN) || ((state == DONE) && seq.StopIn));

  // Sticky overrun flag, cleared only by Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      overrun <= 1'b0;
    end else if (start_drop) begin
      overrun <= 1'b1;
    end
  end

  assign seq.Overrun = overrun;
`else
  assign seq.Overrun = 1'b0;
`endif

endmodule
